// File: rtl/isa_pkg.sv
// Shared ISA definitions: field widths, opcode constants, the nop encoding
// and the fetch-stage state type.
package isa_pkg;

  localparam int OPCODE_W  = 5;
  localparam int OPERAND_W = 12;
  localparam int INSTR_W   = OPCODE_W + OPERAND_W;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_LDAC  = 5'd0;
  localparam opcode_t OP_STAC  = 5'd1;
  localparam opcode_t OP_ADD   = 5'd2;
  localparam opcode_t OP_SUB   = 5'd3;
  localparam opcode_t OP_AND   = 5'd4;
  localparam opcode_t OP_OR    = 5'd5;
  localparam opcode_t OP_XOR   = 5'd6;
  localparam opcode_t OP_SHL   = 5'd7;
  localparam opcode_t OP_SHR   = 5'd8;
  localparam opcode_t OP_INC   = 5'd9;
  localparam opcode_t OP_DEC   = 5'd10;
  localparam opcode_t OP_MOV   = 5'd11;
  localparam opcode_t OP_JPNZ  = 5'd24;
  localparam opcode_t OP_JMPZ  = 5'd26;
  localparam opcode_t OP_NOP   = 5'd28;
  localparam opcode_t OP_ENDOP = 5'd31;

  localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, 12'd0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Loadable program counter that wraps modulo 2^width and holds unless advanced.
module pc_counter #(
  parameter int width = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             load,
  input  logic [width-1:0] load_value,
  output logic [width-1:0] count,
  output logic [width-1:0] count_inc
);

  assign count_inc = count + width'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (advance) begin
      count <= load ? load_value : count_inc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives the synchronous instruction memory and registers the
// returned word into the IR, with branch squash, stall hold and endop halt.
module instr_fetch
  import isa_pkg::*;
#(
  parameter int addr_width  = 11,
  parameter int instr_width = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [OPERAND_W-1:0]   branch_target,
  output logic [addr_width-1:0]  mem_addr,
  input  logic [instr_width-1:0] mem_instr,
  output logic [instr_width-1:0] ir,
  output logic [addr_width-1:0]  ir_pc,
  output logic                   ir_valid,
  output logic                   halted
);

  fetch_state_t state, state_next;

  logic [addr_width-1:0] fetch_pc;
  logic [addr_width-1:0] fetch_pc_inc;
  logic [addr_width-1:0] target;
  logic                  mem_valid;
  logic                  go;
  logic                  step;
  logic                  do_branch;
  logic                  retire_end;
  logic                  ir_is_endop;

  // Operand bits above the memory address width are silently dropped.
  assign target      = addr_width'(branch_target);
  assign ir_is_endop = ir_valid && (ir[instr_width-1 -: OPCODE_W] == OP_ENDOP);

  always_comb begin
    state_next = state;
    go         = 1'b0;
    step       = 1'b0;
    do_branch  = 1'b0;
    retire_end = 1'b0;
    mem_addr   = fetch_pc;
    case (state)
      IDLE: begin
        if (start) begin
          go         = 1'b1;
          state_next = RUN;
          mem_addr   = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          step = 1'b1;
          if (ir_is_endop) begin
            retire_end = 1'b1;
            state_next = HALT;
            mem_addr   = fetch_pc_inc;
          end else if (branch_taken) begin
            do_branch = 1'b1;
            mem_addr  = target;
          end else begin
            mem_addr = fetch_pc_inc;
          end
        end
      end
      default: begin
      end
    endcase
    if (rst) begin
      mem_addr = '0;
    end
  end

  // fetch_pc always follows mem_addr on an advancing edge, so it names the
  // word the memory returns next cycle.
  pc_counter #(
    .width(addr_width)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .advance   (go | step),
    .load      (go | do_branch),
    .load_value(go ? '0 : target),
    .count     (fetch_pc),
    .count_inc (fetch_pc_inc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      ir        <= instr_width'(NOP_WORD);
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
      halted    <= 1'b0;
    end else if (go) begin
      mem_valid <= 1'b1;
    end else if (retire_end) begin
      mem_valid <= 1'b0;
      ir_valid  <= 1'b0;
      halted    <= 1'b1;
    end else if (do_branch) begin
      // The sequential word already in flight is replaced by a bubble.
      mem_valid <= 1'b1;
      ir        <= instr_width'(NOP_WORD);
      ir_pc     <= fetch_pc;
      ir_valid  <= 1'b0;
    end else if (step) begin
      mem_valid <= 1'b1;
      ir        <= mem_instr;
      ir_pc     <= fetch_pc;
      ir_valid  <= mem_valid;
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage of the processor: owns the program counter, drives the address of the synchronous-read instruction memory, and registers the returned 17-bit instruction word into the instruction register (IR) consumed by the control unit. It handles branch redirection with a squashed wrong-path word, holds its state under pipeline stalls, and stops fetching after an `endop`.

## Interface
- `addr_width`, default 11: instruction memory address width (2048 words).
- `instr_width`, default 17: instruction width, opcode [16:12] plus operand [11:0].

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins fetching at address 0. Honoured only in IDLE.
- `stall`  in  1  control unit busy; freezes the whole stage.
- `branch_taken`  in  1  redirect request from the control unit, which has already evaluated the `jpnz`/`jmpz` condition for the IR word.
- `branch_target`  in  12  operand field of the branch; the low `addr_width` bits are used.
- `mem_addr`  out  addr_width  address to instruction memory (combinational).
- `mem_instr`  in  instr_width  memory read data; reflects `mem_addr` from the previous cycle.
- `ir`  out  instr_width  instruction register.
- `ir_pc`  out  addr_width  address of the word in `ir`.
- `ir_valid`  out  1  `ir` holds a real instruction this cycle.
- `halted`  out  1  `endop` retired; fetch stopped.

## Operation
- States: IDLE, RUN, HALT.
- Registers: `fetch_pc` (address of the word now on `mem_instr`), `mem_valid` (that word is wanted), `ir`, `ir_pc`, `ir_valid`, `halted`.
- `mem_addr`:
  - `fetch_pc` when stalled, in IDLE, or in HALT.
  - `branch_target` when `branch_taken` and no stall.
  - `fetch_pc + 1` otherwise.
  - The memory therefore re-reads the same word during a stall, and `mem_instr` stays stable.
- IDLE to RUN on `start`:
  - `mem_addr` = 0 in the `start` cycle.
  - `fetch_pc` <= 0 and `mem_valid` <= 1.
- RUN, no stall, no branch:
  - `ir` <= `mem_instr`; `ir_pc` <= `fetch_pc`; `ir_valid` <= `mem_valid`.
  - `fetch_pc` <= `fetch_pc + 1`, wrapping 2047 to 0 modulo 2^addr_width; `mem_valid` <= 1.
- RUN, branch (no stall):
  - `fetch_pc` <= target.
  - The in-flight sequential word is squashed: `ir` <= nop encoding `{5'd28,12'd0}`, `ir_valid` <= 0.
  - Cost: exactly one bubble.
- Stall has priority over branch. `branch_taken` asserted during `stall` is ignored; the control unit holds it until `stall` drops.
- Stall freezes every register; outputs hold.
- `endop` (opcode 31) loaded into `ir`:
  - The next unstalled edge enters HALT, sets `halted` = 1 and `ir_valid` <= 0.
  - The prefetched word is discarded.
  - HALT is exited only by `rst`; `start` is ignored.
- Target truncation: operand bits above `addr_width` are dropped without error.

## Timing
- Reset values: state IDLE, `fetch_pc` 0, `mem_valid` 0, `ir` = nop encoding, `ir_pc` 0, `ir_valid` 0, `halted` 0. `mem_addr` = 0 while in reset.
- Start latency: `start` at cycle t gives `mem_instr` = ram[0] at t+1, and `ir` = ram[0] with `ir_valid` = 1 at t+2.
- Throughput: one instruction per cycle when unstalled.
- Branch seen at t: `ir_valid` = 0 at t+1, and `ir` = ram[target] with `ir_valid` = 1 at t+2.
- `rst` mid-run takes effect at the next edge regardless of `stall` or `branch_taken`.

## Structure
- Shared package `isa_pkg`:
  - Opcode constants: nop 28, endop 31, jpnz 24, jmpz 26, plus the remaining opcodes.
  - Field widths: opcode 5, operand 12, instruction 17.
  - Nop encoding constant.
- Optional sub-module `pc_counter`: loadable, wrapping counter with hold enable. Everything else stays in `instr_fetch`.

## Test plan
- Sequential fetch: memory preloaded 0..9, `start` at cycle 0 -> `ir_pc` = 0,1,2,… on consecutive cycles from cycle 2, `ir_valid` continuously 1.
- Branch: `branch_taken` with target 66 while `ir_pc` = 52 -> one cycle with `ir_valid` = 0 and `ir` = nop, then `ir_pc` = 66, 67.
- Stall: hold `stall` 3 cycles with `ir_pc` = 5, branch requested mid-stall -> `ir`/`ir_pc`/`mem_addr` frozen and branch ignored; after release, `ir_pc` = 6 with no word lost or duplicated.
- Endop: `endop` at address 103 -> `ir` = `{5'd31,12'd0}` one cycle, then `halted` = 1, `ir_valid` = 0, `mem_addr` constant; a later `start` has no effect.
- Wrap: branch to 2046 -> `ir_pc` 2046, 2047, 0, 1.
- Reset mid-run: `rst` at `ir_pc` = 20 -> next cycle all outputs at reset values; a subsequent `start` refetches from 0.
